// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch path: opcode field,
// terminating opcodes and the fetch sequencer state encoding.
package imem_pkg;

    localparam int         OPCODE_MSB   = 31;
    localparam logic [3:0] OP_BLOCK_END = 4'hE;
    localparam logic [3:0] OP_PROG_END  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BLK = 3'd1,
        ST_FETCH    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_REARM    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO carrying an instruction word plus its last flag;
// head outputs come straight from storage and read as zero while empty.
module inst_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       push_last,
    input  logic                       pop,
    output logic                       valid,
    output logic [DATA_W-1:0]          head_data,
    output logic                       head_last,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W:0] storage [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign valid     = (count != '0);
    assign do_pop    = pop && valid;
    assign do_push   = push && ((count != (PW+1)'(DEPTH)) || do_pop);
    assign head_data = valid ? storage[rd_ptr][DATA_W-1:0] : '0;
    assign head_last = valid ? storage[rd_ptr][DATA_W] : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= {push_last, push_data};
    end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Streams one buffer of the double-buffered instruction memory into the
// decoder FIFO, replaying missed reads, and hands the buffer back when done.
module imem_fetch_sequencer #(
    parameter int         INST_DATA_WIDTH = 32,
    parameter int         INST_ADDR_WIDTH = 10,
    parameter int         OPCODE_MSB      = imem_pkg::OPCODE_MSB,
    parameter logic [3:0] OP_BLOCK_END    = imem_pkg::OP_BLOCK_END,
    parameter logic [3:0] OP_PROG_END     = imem_pkg::OP_PROG_END,
    parameter int         FIFO_DEPTH      = 4,
    parameter int         REARM_GAP       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       done,
    input  logic                       imem_block_ready,
    output logic                       imem_rd_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
    input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
    input  logic                       imem_rd_valid,
    output logic                       imem_rd_block_done,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic                       inst_last,
    output logic                       addr_overflow
);

    import imem_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam int GW = (REARM_GAP > 1) ? $clog2(REARM_GAP) : 1;
    localparam logic [INST_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    fetch_state_t               state;
    logic [INST_ADDR_WIDTH-1:0] nxt_addr;
    logic                       exp_live_p1;
    logic [INST_ADDR_WIDTH-1:0] exp_addr_p1;
    logic [GW-1:0]              gap_cnt;
    logic [CW-1:0]              fifo_count;

    logic                       rsp_hit;
    logic                       rsp_miss;
    logic                       rsp_end;
    logic                       push_last;
    logic                       stop;
    logic                       req_live;
    logic                       fifo_pop;
    logic                       can_issue;
    logic                       last_pop;
    logic [INST_ADDR_WIDTH-1:0] base_addr;
    logic [OW-1:0]              occ_next;

    // Response stage: the request registered last cycle is answered (or missed) now
    always_comb begin
        rsp_hit   = (state == ST_FETCH) && exp_live_p1 && imem_rd_valid;
        rsp_miss  = (state == ST_FETCH) && exp_live_p1 && !imem_rd_valid;
        rsp_end   = (imem_rd_data[OPCODE_MSB -: 4] == OP_BLOCK_END) ||
                    (imem_rd_data[OPCODE_MSB -: 4] == OP_PROG_END);
        push_last = rsp_end || (exp_addr_p1 == '1);
        stop      = rsp_hit && push_last;
        req_live  = imem_rd_req && !rsp_miss;
        base_addr = rsp_miss ? exp_addr_p1 : nxt_addr;
        fifo_pop  = inst_valid && inst_ready;
        last_pop  = fifo_pop && inst_last;
        // occupancy once this cycle settles, plus the read still in flight
        occ_next  = OW'(fifo_count) + OW'(rsp_hit) - OW'(fifo_pop) + OW'(req_live);
        can_issue = occ_next < OW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            imem_rd_req        <= 1'b0;
            imem_rd_addr       <= '0;
            imem_rd_block_done <= 1'b0;
            done               <= 1'b0;
            addr_overflow      <= 1'b0;
            exp_live_p1        <= 1'b0;
            gap_cnt            <= '0;
        end else begin
            imem_rd_block_done <= 1'b0;
            done               <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_WAIT_BLK;
                end
                ST_WAIT_BLK: begin
                    if (imem_block_ready) begin
                        state        <= ST_FETCH;
                        imem_rd_req  <= 1'b1;
                        imem_rd_addr <= '0;
                        nxt_addr     <= ADDR_ONE;
                        exp_live_p1  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    exp_live_p1 <= req_live && !stop;
                    exp_addr_p1 <= imem_rd_addr;
                    if (stop) begin
                        state       <= ST_DRAIN;
                        imem_rd_req <= 1'b0;
                        if (!rsp_end) addr_overflow <= 1'b1;
                    end else if (can_issue) begin
                        imem_rd_req  <= 1'b1;
                        imem_rd_addr <= base_addr;
                        nxt_addr     <= base_addr + ADDR_ONE;
                    end else begin
                        imem_rd_req <= 1'b0;
                        nxt_addr    <= base_addr;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        imem_rd_block_done <= 1'b1;
                        if (inst_data[OPCODE_MSB -: 4] == OP_PROG_END) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_REARM;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_REARM: begin
                    if (gap_cnt == GW'(REARM_GAP - 1)) state <= ST_WAIT_BLK;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    inst_fifo #(
        .DATA_W (INST_DATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_hit),
        .push_data (imem_rd_data),
        .push_last (push_last),
        .pop       (inst_ready),
        .valid     (inst_valid),
        .head_data (inst_data),
        .head_last (inst_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: random block images, a read-latency memory
// model with miss injection, and a decoder with selectable backpressure.
module tb_imem_fetch_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int NW    = 1 << AW;
    localparam int DEPTH = 4;
    localparam int GAP   = 3;

    logic          clk = 1'b0;
    logic          reset, start, done;
    logic          imem_block_ready, imem_rd_req, imem_rd_valid, imem_rd_block_done;
    logic [AW-1:0] imem_rd_addr;
    logic [DW-1:0] imem_rd_data, inst_data;
    logic          inst_valid, inst_ready, inst_last, addr_overflow;

    always #5 clk = ~clk;

    imem_fetch_sequencer #(
        .INST_DATA_WIDTH (DW),
        .INST_ADDR_WIDTH (AW),
        .FIFO_DEPTH      (DEPTH),
        .REARM_GAP       (GAP)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .imem_block_ready   (imem_block_ready),
        .imem_rd_req        (imem_rd_req),
        .imem_rd_addr       (imem_rd_addr),
        .imem_rd_data       (imem_rd_data),
        .imem_rd_valid      (imem_rd_valid),
        .imem_rd_block_done (imem_rd_block_done),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .inst_data          (inst_data),
        .inst_last          (inst_last),
        .addr_overflow      (addr_overflow)
    );

    logic [DW-1:0] mem [NW];
    int n_chk = 0, n_fail = 0;
    int miss_target = 0, miss_used = 0;
    int ready_mode = 0;
    int bd_cnt = 0, dn_cnt = 0, both_cnt = 0, bd_got = 0;
    int bd0 = 0, dn0 = 0;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [AW-1:0] req_q[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic          exp_done, exp_ovf, ovf_sticky = 1'b0;

    // Memory: answers a request one cycle later unless told to withhold it
    initial begin
        logic          r;
        logic [AW-1:0] a;
        imem_rd_valid = 1'b0;
        imem_rd_data  = '0;
        forever begin
            @(negedge clk);
            r = imem_rd_req;
            a = imem_rd_addr;
            @(posedge clk);
            #1;
            if (r === 1'b1 && miss_used < miss_target) begin
                miss_used++;
                imem_rd_valid = 1'b0;
                imem_rd_data  = $urandom;
            end else begin
                imem_rd_valid = (r === 1'b1);
                imem_rd_data  = (r === 1'b1) ? mem[a] : $urandom;
            end
        end
    end

    initial begin
        inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       inst_ready = 1'b1;
                1:       inst_ready = 1'($urandom_range(0, 1));
                default: inst_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                got_d.push_back(inst_data);
                got_l.push_back(inst_last);
            end
            if (imem_rd_block_done === 1'b1) begin
                bd_cnt++;
                bd_got = got_d.size();
            end
            if (done === 1'b1) dn_cnt++;
            if (done === 1'b1 && imem_rd_block_done === 1'b1) both_cnt++;
            if (imem_rd_req === 1'b1) req_q.push_back(imem_rd_addr);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input int len, input logic [3:0] endop, input bit has_end);
        for (int i = 0; i < NW; i++)
            mem[i] = {4'($urandom_range(0, 13)), 28'($urandom)};
        if (has_end) mem[len-1][31:28] = endop;
    endtask

    // Reference: words in address order up to the first end opcode or the last address
    task automatic prep();
        logic [3:0] op;
        logic       fin;
        exp_d.delete();
        exp_l.delete();
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            op  = mem[i][31:28];
            fin = (op == 4'hE) || (op == 4'hF) || (i == NW - 1);
            exp_d.push_back(mem[i]);
            exp_l.push_back(fin);
            if (fin) begin
                exp_done = (op == 4'hF);
                exp_ovf  = !((op == 4'hE) || (op == 4'hF));
                break;
            end
        end
        got_d.delete();
        got_l.delete();
        req_q.delete();
        dn0 = dn_cnt;
        bd0 = bd_cnt;
    endtask

    task automatic wait_bd(input string tag);
        int k;
        k = 0;
        while (bd_cnt == bd0 && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_block_done_seen"}, 64'(bd_cnt != bd0), 64'd1);
    endtask

    task automatic check_block(input string tag);
        check({tag, "_beats"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
        check({tag, "_bd_after_last"}, 64'(bd_got), 64'(exp_d.size()));
        check({tag, "_done_pulses"}, 64'(dn_cnt - dn0), 64'(exp_done));
        ovf_sticky = ovf_sticky | exp_ovf;
        check({tag, "_overflow"}, 64'(addr_overflow), 64'(ovf_sticky));
    endtask

    initial begin
        int k, n0;
        reset = 1'b1;
        start = 1'b0;
        imem_block_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_rd_req", 64'(imem_rd_req), 64'd0);
        check("rst_block_done", 64'(imem_rd_block_done), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(addr_overflow), 64'd0);
        check("rst_inst_last", 64'(inst_last), 64'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Started but no buffer ready: nothing is requested
        req_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("wait_blk_no_req", 64'(req_q.size()), 64'd0);

        // Basic block, decoder always ready
        load_block(8, 4'hE, 1'b0);
        mem[0] = 32'h1234_5678;
        mem[1] = 32'h2345_6789;
        mem[2] = 32'hE000_0000;
        prep();
        ready_mode = 0;
        imem_block_ready = 1'b1;
        wait_bd("basic");
        check_block("basic");

        // Next block fetch starts after the rearm gap plus one WAIT_BLK cycle
        load_block(5, 4'hE, 1'b1);
        prep();
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (imem_rd_req === 1'b1) break;
        end
        check("rearm_latency", 64'(k), 64'(GAP + 1));
        check("basic_single_bd", 64'(bd_cnt - bd0 + 1), 64'd1);
        ready_mode = 1;
        wait_bd("rand5");
        check_block("rand5");

        // Miss replay: first two requests withheld
        load_block(3, 4'hE, 1'b1);
        prep();
        miss_target = miss_used + 2;
        wait_bd("miss");
        check_block("miss");
        n0 = 0;
        foreach (req_q[i]) if (req_q[i] == '0) n0++;
        check("miss_addr0_reissued", 64'(n0 >= 2), 64'd1);

        // Backpressure during an 8-instruction block
        load_block(8, 4'hE, 1'b1);
        prep();
        ready_mode = 2;
        repeat (14) tick();
        @(negedge clk);
        check("bp_inst_valid", 64'(inst_valid), 64'd1);
        check("bp_rd_req_low", 64'(imem_rd_req), 64'd0);
        check("bp_requests_bounded", 64'(req_q.size()), 64'(DEPTH));
        check("bp_no_bd_early", 64'(bd_cnt - bd0), 64'd0);
        ready_mode = 0;
        wait_bd("bp");
        check_block("bp");

        // Program end: block_done and done together, then idle
        load_block($urandom_range(2, 6), 4'hF, 1'b1);
        prep();
        ready_mode = 1;
        n0 = both_cnt;
        wait_bd("prog");
        check_block("prog");
        check("prog_done_with_bd", 64'(both_cnt - n0), 64'd1);
        req_q.delete();
        repeat (10) tick();
        check("idle_after_prog_end", 64'(req_q.size()), 64'd0);

        // Restart after program end
        load_block(3, 4'hE, 1'b1);
        prep();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bd("restart");
        check_block("restart");

        // Overflow: no end opcode anywhere in the buffer
        load_block(NW, 4'h0, 1'b0);
        prep();
        wait_bd("ovf");
        check_block("ovf");
        load_block(2, 4'hE, 1'b1);
        prep();
        wait_bd("ovf_sticky");
        check_block("ovf_sticky");

        // Reset with entries queued in the FIFO
        load_block(8, 4'hE, 1'b1);
        prep();
        ready_mode = 2;
        k = 0;
        while (k < 40 && inst_valid !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_fifo_filled", 64'(inst_valid), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_inst_valid", 64'(inst_valid), 64'd0);
        check("midrst_rd_req", 64'(imem_rd_req), 64'd0);
        check("midrst_block_done", 64'(imem_rd_block_done), 64'd0);
        check("midrst_overflow", 64'(addr_overflow), 64'd0);
        check("midrst_inst_last", 64'(inst_last), 64'd0);
        tick();
        reset = 1'b0;
        imem_block_ready = 1'b0;
        ready_mode = 0;
        repeat (10) tick();
        check("midrst_no_bd", 64'(bd_cnt - bd0), 64'd0);
        check("midrst_no_beats", 64'(got_d.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sits directly downstream of the double-buffered instruction memory and upstream of the instruction decoder.
- Once the active buffer holds a block, it streams that block out of the memory with back-to-back reads.
- Instructions go to the decoder through a valid/ready interface, backed by a small output FIFO.
- It detects end-of-block and end-of-program instructions and hands the buffer back to the memory with a one-cycle block-done pulse.

Parameters:
- INST_DATA_WIDTH, 32, instruction width.
- INST_ADDR_WIDTH, 10, per-buffer read address width.
- OPCODE_MSB, 31, top bit of the 4-bit opcode field `[OPCODE_MSB -: 4]`.
- OP_BLOCK_END, 4'hE, opcode that terminates a block.
- OP_PROG_END, 4'hF, opcode that terminates a block and the program.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ 2).
- REARM_GAP, 3, cycles after a block-done pulse before imem_block_ready is sampled again.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, begin program fetch
- done  out  1  one-cycle pulse after the PROG_END instruction is accepted by the decoder
- imem_block_ready  in  1  memory holds at least one filled buffer
- imem_rd_req  out  1  read request
- imem_rd_addr  out  INST_ADDR_WIDTH  read address within the current buffer
- imem_rd_data  in  INST_DATA_WIDTH  read data, valid with imem_rd_valid
- imem_rd_valid  in  1  response to the request of the previous cycle
- imem_rd_block_done  out  1  one-cycle pulse, current buffer consumed
- inst_valid  out  1  instruction available to the decoder
- inst_ready  in  1  decoder accepts
- inst_data  out  INST_DATA_WIDTH  instruction
- inst_last  out  1  instruction is BLOCK_END or PROG_END
- addr_overflow  out  1  sticky; block ran to the last address without an end opcode

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, address 0. Reset mid-block discards the FIFO and any in-flight read; no block-done pulse is issued.
- States: IDLE, WAIT_BLK, FETCH, DRAIN, REARM.
- IDLE → WAIT_BLK on start. start is ignored in any other state.
- WAIT_BLK → FETCH when imem_block_ready=1. The address pointer resets to 0 on entering FETCH.
- FETCH, issue rule: drive imem_rd_req=1 at addr A when `(fifo_count + inflight) < FIFO_DEPTH`.
- FETCH, read latency is 1 cycle:
  - A request at cycle t expects imem_rd_valid at t+1.
  - With valid at t+1: push the data and advance the acknowledged address to A+1.
  - Without valid at t+1 (a miss, e.g. the memory has not yet entered its data phase): drop the request issued at t+1, and ignore any imem_rd_valid at t+2. Re-issue from A starting at t+2.
  - Net effect: instructions enter the FIFO strictly in address order, with no gaps or duplicates.
- FETCH, end detection:
  - A pushed word whose opcode is BLOCK_END or PROG_END sets inst_last on that entry.
  - Issuing stops at once; the in-flight response after the end word is discarded.
  - FETCH → DRAIN.
- FETCH, address overflow: if address 2^INST_ADDR_WIDTH−1 is pushed without an end opcode:
  - set addr_overflow;
  - mark that entry inst_last;
  - go to DRAIN.
- DRAIN: wait until the inst_last entry is accepted (inst_valid & inst_ready & inst_last). In that cycle:
  - register imem_rd_block_done=1 for the next cycle;
  - if the entry was PROG_END, also register done=1 for the next cycle and go to IDLE; otherwise go to REARM.
- REARM: count REARM_GAP cycles, then → WAIT_BLK. The gap covers the memory's DONE→WAIT transition and its not-empty flag update.
- FIFO:
  - Push and pop in the same cycle are allowed when the FIFO is full or empty.
  - inst_valid = !empty, with data and last taken from the head entry. Outputs are registered from FIFO storage with no combinational path from inst_ready.
  - Pointers wrap modulo FIFO_DEPTH, with count 0..FIFO_DEPTH.
  - The issue rule guarantees the FIFO never overflows.
- imem_rd_req, imem_rd_addr and imem_rd_block_done are driven from registers.

Decomposition:
- Shared package `imem_pkg`: opcode constants OP_BLOCK_END and OP_PROG_END, the opcode field position, and the fetch state encoding (3 bits).
- Sub-module `inst_fifo` (sync FIFO, data + last, DEPTH parameter) instantiated once; the FSM, replay and issue logic stay in the top level.

Test Plan:
- Basic block, decoder always ready:
  - Stimulus: start, block_ready=1, memory holds 0x1…, 0x2…, 0xE0000000 at addresses 0–2.
  - Response: three inst_valid beats in order; inst_last on the third only; a single block_done pulse; return to WAIT_BLK after 3 cycles.
- Miss replay:
  - Stimulus: memory withholds rd_valid for the first 2 requests.
  - Response: address 0 is re-issued; the decoder sees addresses 0, 1, 2 exactly once, in order.
- Backpressure:
  - Stimulus: inst_ready=0 for 10 cycles during an 8-instruction block.
  - Response: at most 4 outstanding entries; imem_rd_req deasserts; no loss or duplication; block_done only after the last beat is accepted.
- Program end:
  - Stimulus: second block ends with 0xF0000000.
  - Response: block_done and done pulse in the same cycle; state returns to IDLE; a later start restarts fetch.
- Overflow:
  - Stimulus: INST_ADDR_WIDTH=3, 8 words with no end opcode.
  - Response: the eighth beat has inst_last=1; addr_overflow stays 1; block_done pulses.
- Reset mid-block:
  - Stimulus: assert reset with the FIFO holding 2 entries.
  - Response: next cycle inst_valid=0, imem_rd_req=0, no block_done pulse, addr_overflow=0.
